shapool_job_controller: RTL

- Sequences one shapool search job. It latches a nonce range when a job is loaded, releases the core from reset, and feeds base nonces one per cycle.
- It tracks the pipeline latency, so the winning nonce is reported exactly. The host does not apply a nonce-1 correction.
- It detects range exhaustion and holds the result until the IO layer acknowledges it.
- It sits between external_io (job/result side) and the shapool core.

---
 rtl/shapool_pkg.sv | 17 +
 rtl/shapool_nonce_tracker.sv | 42 ++++
 rtl/shapool_job_controller.sv | 123 ++++++++++++
 3 files changed

// File: rtl/shapool_pkg.sv
// Shared constants and FSM encoding for the shapool job controller and core.
package shapool_pkg;

    localparam int DEFAULT_NONCE_WIDTH = 32;
    localparam int SHA_ROUNDS          = 64;
    // Round pipeline plus its input register and digest compare stage.
    localparam int CORE_LATENCY        = SHA_ROUNDS + 2;

    typedef enum logic [2:0] {
        STATE_IDLE  = 3'd0,
        STATE_PRIME = 3'd1,
        STATE_RUN   = 3'd2,
        STATE_DRAIN = 3'd3,
        STATE_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/shapool_nonce_tracker.sv
// Nonce tag register, end-of-range compare and latency-corrected result capture.
module shapool_nonce_tracker #(
    parameter int NONCE_WIDTH = 32,
    parameter int LATENCY     = 66
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic                   advance,
    input  logic                   capture,
    input  logic [NONCE_WIDTH-1:0] start,
    input  logic [NONCE_WIDTH-1:0] last,
    output logic [NONCE_WIDTH-1:0] tag,
    output logic [NONCE_WIDTH-1:0] result,
    output logic                   at_end
);

    logic [NONCE_WIDTH-1:0] last_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tag    <= '0;
            last_q <= '0;
            result <= '0;
        end else begin
            if (load) begin
                tag    <= start;
                last_q <= last;
                result <= '0;
            end else if (advance) begin
                tag <= tag + NONCE_WIDTH'(1);
            end
            // The hit belongs to the nonce issued LATENCY cycles ago.
            if (capture) begin
                result <= tag - NONCE_WIDTH'(LATENCY);
            end
        end
    end

    assign at_end = (tag == last_q);

endmodule

// File: rtl/shapool_job_controller.sv
// Sequences one shapool search job: prime, issue nonces, drain, report.
module shapool_job_controller
    import shapool_pkg::*;
#(
    parameter int NONCE_WIDTH = DEFAULT_NONCE_WIDTH,
    parameter int LATENCY     = CORE_LATENCY,
    parameter int DRAIN_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   job_load,
    input  logic [NONCE_WIDTH-1:0] nonce_start,
    input  logic [NONCE_WIDTH-1:0] nonce_end,
    input  logic                   core_success,
    input  logic                   result_ack,
    output logic                   core_reset_n,
    output logic                   core_enable,
    output logic [NONCE_WIDTH-1:0] core_nonce,
    output logic [NONCE_WIDTH-1:0] result_nonce,
    output logic                   result_found,
    output logic                   exhausted,
    output logic                   busy
);

    state_t                 state_q, state_d;
    logic [DRAIN_WIDTH-1:0] drain_q, drain_d;
    logic                   found_q, found_d;
    logic                   exh_q, exh_d;
    logic                   busy_q;
    logic                   load, advance, capture, at_end;

    shapool_nonce_tracker #(
        .NONCE_WIDTH(NONCE_WIDTH),
        .LATENCY    (LATENCY)
    ) u_tracker (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (load),
        .advance(advance),
        .capture(capture),
        .start  (nonce_start),
        .last   (nonce_end),
        .tag    (core_nonce),
        .result (result_nonce),
        .at_end (at_end)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= STATE_IDLE;
            drain_q <= '0;
            found_q <= 1'b0;
            exh_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            found_q <= found_d;
            exh_q   <= exh_d;
            busy_q  <= (state_d != STATE_IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        found_d = found_q;
        exh_d   = exh_q;
        load    = 1'b0;
        capture = 1'b0;
        case (state_q)
            STATE_IDLE: begin
                if (job_load) begin
                    load    = 1'b1;
                    state_d = STATE_PRIME;
                end
            end
            STATE_PRIME: state_d = STATE_RUN;
            STATE_RUN: begin
                if (core_success) begin
                    capture = 1'b1;
                    found_d = 1'b1;
                    state_d = STATE_DONE;
                end else if (at_end) begin
                    drain_d = DRAIN_WIDTH'(LATENCY);
                    state_d = STATE_DRAIN;
                end
            end
            // Success is checked first so a hit on the final drain cycle wins.
            STATE_DRAIN: begin
                drain_d = drain_q - DRAIN_WIDTH'(1);
                if (core_success) begin
                    capture = 1'b1;
                    found_d = 1'b1;
                    state_d = STATE_DONE;
                end else if (drain_q == DRAIN_WIDTH'(1)) begin
                    exh_d   = 1'b1;
                    state_d = STATE_DONE;
                end
            end
            STATE_DONE: begin
                if (result_ack) begin
                    found_d = 1'b0;
                    exh_d   = 1'b0;
                    state_d = STATE_IDLE;
                end
            end
            default: begin
                found_d = 1'b0;
                exh_d   = 1'b0;
                state_d = STATE_IDLE;
            end
        endcase
    end

    assign advance      = (state_q == STATE_RUN) || (state_q == STATE_DRAIN);
    assign core_enable  = (state_q == STATE_RUN);
    assign core_reset_n = busy_q;
    assign busy         = busy_q;
    assign result_found = found_q;
    assign exhausted    = exh_q;

endmodule
